// File: rtl/channel_mixer_pkg.sv
// Shared definitions for the channel mixer.
// Provides the default mixer geometry, the accumulator width helper, the packed input-beat
// record used by upstream sequencing, and the mixer FSM state type.
package channel_mixer_pkg;

    localparam int unsigned MIX_IN_WIDTH     = 15;
    localparam int unsigned MIX_NUM_CHANNELS = 18;
    localparam int unsigned MIX_NUM_OUTPUTS  = 4;
    localparam int unsigned MIX_ATTEN_WIDTH  = 3;
    localparam int unsigned MIX_CHAN_WIDTH   = $clog2(MIX_NUM_CHANNELS);

    // Headroom: one sign bit plus one guard bit above the channel-count growth.
    function automatic int unsigned mix_acc_width(int unsigned in_w, int unsigned num_ch);
        return in_w + $clog2(num_ch) + 2;
    endfunction

    localparam int unsigned MIX_ACC_WIDTH = mix_acc_width(MIX_IN_WIDTH, MIX_NUM_CHANNELS);

    typedef struct packed {
        logic [MIX_CHAN_WIDTH-1:0]      chan;
        logic signed [MIX_IN_WIDTH-1:0] data;
        logic [MIX_NUM_OUTPUTS-1:0]     route;
        logic [MIX_ATTEN_WIDTH-1:0]     atten;
        logic                           last;
    } mix_in_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StClamp,
        StPresent
    } mix_state_e;

endpackage

// File: rtl/channel_mixer_sat_clamp.sv
// sat_clamp: signed saturator from IN_W to OUT_W bits (IN_W >= OUT_W).
// Ports:
//   value  - signed input
//   result - value clamped to the signed OUT_W range
//   clip   - high when value was outside that range
module sat_clamp #(
    parameter int unsigned IN_W  = 23,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result,
    output logic                    clip
);

    localparam logic signed [IN_W-1:0] MaxVal =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MinVal =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        result = value[OUT_W-1:0];
        clip   = 1'b0;
        if (value > MaxVal) begin
            result = {1'b0, {(OUT_W-1){1'b1}}};
            clip   = 1'b1;
        end else if (value < MinVal) begin
            result = {1'b1, {(OUT_W-1){1'b0}}};
            clip   = 1'b1;
        end
    end

endmodule

// File: rtl/channel_mixer.sv
// channel_mixer: accumulates per-channel samples onto NUM_OUTPUTS buses, optionally folds
// the upper half of the buses onto the lower half, saturates, and presents one frame.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   frame_start              - begins (or aborts and restarts) a frame
//   in_valid/in_chan/in_data - channel sample stream, with route mask, attenuation shift
//   in_route/in_atten/in_last  and end-of-frame marker
//   cfg_fold                 - fold bus k+NUM_OUTPUTS/2 into bus k (sampled in CLAMP)
//   busy                     - frame in ACCUM or CLAMP
//   out_valid                - one-cycle pulse when out_sample/out_clip update
//   out_sample/out_clip      - saturated bus values and per-bus clip flags
//   err_dup                  - duplicate/invalid channel or aborted frame, sticky per frame
module channel_mixer
    import channel_mixer_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = 15,
    parameter int unsigned OUT_WIDTH    = 16,
    parameter int unsigned NUM_CHANNELS = 18,
    parameter int unsigned NUM_OUTPUTS  = 4,
    parameter int unsigned ATTEN_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_start,
    input  logic                             in_valid,
    input  logic [$clog2(NUM_CHANNELS)-1:0]  in_chan,
    input  logic signed [IN_WIDTH-1:0]       in_data,
    input  logic [NUM_OUTPUTS-1:0]           in_route,
    input  logic [ATTEN_WIDTH-1:0]           in_atten,
    input  logic                             in_last,
    input  logic                             cfg_fold,
    output logic                             busy,
    output logic                             out_valid,
    output logic [NUM_OUTPUTS*OUT_WIDTH-1:0] out_sample,
    output logic [NUM_OUTPUTS-1:0]           out_clip,
    output logic                             err_dup
);

    localparam int unsigned CHAN_W    = $clog2(NUM_CHANNELS);
    localparam int unsigned ACC_WIDTH = mix_acc_width(IN_WIDTH, NUM_CHANNELS);
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
    localparam int unsigned HALF      = NUM_OUTPUTS / 2;

    mix_state_e                  state_q;
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_OUTPUTS];
    logic [NUM_CHANNELS-1:0]     seen_q;
    logic [CHAN_W:0]             count_q;

    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] term;
    logic                        chan_ok;
    logic                        accept;
    logic                        frame_done;
    logic signed [OUT_WIDTH-1:0] sat [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0]      clip;

    assign data_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign term     = data_ext >>> in_atten;

    assign chan_ok    = {1'b0, in_chan} < (CHAN_W+1)'(NUM_CHANNELS);
    assign accept     = in_valid && chan_ok && !seen_q[in_chan];
    // A frame ends on an in_last beat even if that beat itself is dropped.
    assign frame_done = in_valid &&
        (in_last || (accept && count_q == (CHAN_W+1)'(NUM_CHANNELS - 1)));

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_bus
        logic signed [SUM_WIDTH-1:0] pre;
        if (k < HALF) begin : g_low
            assign pre = cfg_fold ? SUM_WIDTH'(acc_q[k]) + SUM_WIDTH'(acc_q[k+HALF])
                                  : SUM_WIDTH'(acc_q[k]);
        end else begin : g_high
            assign pre = cfg_fold ? '0 : SUM_WIDTH'(acc_q[k]);
        end
        sat_clamp #(
            .IN_W  (SUM_WIDTH),
            .OUT_W (OUT_WIDTH)
        ) u_sat (
            .value  (pre),
            .result (sat[k]),
            .clip   (clip[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            for (int k = 0; k < NUM_OUTPUTS; k++) acc_q[k] <= '0;
            seen_q     <= '0;
            count_q    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_clip   <= '0;
            err_dup    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        for (int k = 0; k < NUM_OUTPUTS; k++) acc_q[k] <= '0;
                        seen_q  <= '0;
                        count_q <= '0;
                        err_dup <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (frame_start) begin
                        // Abort: restart the frame but keep the error visible.
                        for (int k = 0; k < NUM_OUTPUTS; k++) acc_q[k] <= '0;
                        seen_q  <= '0;
                        count_q <= '0;
                        err_dup <= 1'b1;
                    end else if (in_valid) begin
                        if (accept) begin
                            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                                if (in_route[k]) acc_q[k] <= acc_q[k] + term;
                            end
                            seen_q[in_chan] <= 1'b1;
                            count_q         <= count_q + 1'b1;
                        end else begin
                            err_dup <= 1'b1;
                        end
                        if (frame_done) state_q <= StClamp;
                    end
                end
                StClamp: begin
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        out_sample[k*OUT_WIDTH +: OUT_WIDTH] <= sat[k];
                    end
                    out_clip  <= clip;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StPresent;
                end
                StPresent: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_mixer.sv
module tb_channel_mixer;
    import channel_mixer_pkg::*;

    localparam int NCH  = 18;
    localparam int NOUT = 4;
    localparam int OW   = 16;

    logic        clk = 1'b0;
    logic        reset, frame_start, in_valid, in_last, cfg_fold;
    logic [4:0]  in_chan;
    logic signed [14:0] in_data;
    logic [3:0]  in_route;
    logic [2:0]  in_atten;
    logic        busy, out_valid, err_dup;
    logic [63:0] out_sample;
    logic [3:0]  out_clip;

    always #5 clk = ~clk;

    channel_mixer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_chan     (in_chan),
        .in_data     (in_data),
        .in_route    (in_route),
        .in_atten    (in_atten),
        .in_last     (in_last),
        .cfg_fold    (cfg_fold),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .out_clip    (out_clip),
        .err_dup     (err_dup)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: frame-level bookkeeping in plain integers.
    int macc[NOUT];
    bit mseen[NCH];
    int mcount;
    bit mactive;
    bit merr;
    logic [63:0] exp_sample;
    logic [3:0]  exp_clip;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int floor_shift(input int d, input int a);
        int p = 1 << a;
        int q = d / p;
        if (d < 0 && (d % p) != 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NOUT; k++) macc[k] = 0;
        for (int c = 0; c < NCH; c++) mseen[c] = 1'b0;
        mcount = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_chan = '0; in_data = '0; in_route = '0; in_atten = '0;
        tick();
        reset = 1'b0;
        model_clear();
        mactive = 1'b0; merr = 1'b0; exp_sample = '0; exp_clip = '0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        merr = mactive;  // starting while a frame is open is an abort
        model_clear();
        mactive = 1'b1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("err_dup_after_start", {63'd0, err_dup}, {63'd0, merr});
    endtask

    task automatic send(input int chan, input int data, input logic [3:0] route,
                        input int atten, input bit last, output bit ended);
        in_valid = 1'b1; in_chan = chan[4:0]; in_data = data[14:0];
        in_route = route; in_atten = atten[2:0]; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        ended = 1'b0;
        if (mactive) begin
            if (chan < NCH && !mseen[chan]) begin
                for (int k = 0; k < NOUT; k++)
                    if (route[k]) macc[k] += floor_shift(data, atten);
                mseen[chan] = 1'b1;
                mcount++;
            end else begin
                merr = 1'b1;
            end
            if (last || mcount == NCH) begin
                mactive = 1'b0;
                ended = 1'b1;
            end
        end
    endtask

    // Called right after the frame-ending beat: DUT is in its clamp cycle now.
    task automatic expect_frame(input string tag);
        int v;
        for (int k = 0; k < NOUT; k++) begin
            if (cfg_fold) v = (k < NOUT/2) ? macc[k] + macc[k+NOUT/2] : 0;
            else          v = macc[k];
            exp_clip[k] = 1'b0;
            if (v > 32767)  begin v = 32767;  exp_clip[k] = 1'b1; end
            if (v < -32768) begin v = -32768; exp_clip[k] = 1'b1; end
            exp_sample[k*OW +: OW] = v[15:0];
        end
        chk({tag, "/valid_early"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "/busy_clamp"}, {63'd0, busy}, 64'd1);
        tick();
        chk({tag, "/valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "/sample"}, out_sample, exp_sample);
        chk({tag, "/clip"}, {60'd0, out_clip}, {60'd0, exp_clip});
        chk({tag, "/err_dup"}, {63'd0, err_dup}, {63'd0, merr});
        tick();
        chk({tag, "/valid_once"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "/busy_idle"}, {63'd0, busy}, 64'd0);
        cfg_fold = ~cfg_fold;
        tick();
        chk({tag, "/hold"}, out_sample, exp_sample);
        chk({tag, "/err_dup_sticky"}, {63'd0, err_dup}, {63'd0, merr});
    endtask

    initial begin
        bit e;
        int n, d;
        cfg_fold = 1'b0;
        do_reset();
        chk("reset/busy", {63'd0, busy}, 64'd0);
        chk("reset/valid", {63'd0, out_valid}, 64'd0);
        chk("reset/sample", out_sample, 64'd0);
        chk("reset/clip", {60'd0, out_clip}, 64'd0);
        chk("reset/err_dup", {63'd0, err_dup}, 64'd0);

        // Samples while idle must be ignored.
        send(2, 5000, 4'b1111, 0, 1'b1, e);
        chk("idle/no_valid", {63'd0, out_valid}, 64'd0);

        // 1: basic routing with attenuation.
        cfg_fold = 1'b0;
        pulse_start();
        send(0, 1000, 4'b0001, 0, 1'b0, e);
        send(1, -200, 4'b0011, 1, 1'b1, e);
        expect_frame("basic");

        // 2: fold, full frame ending on count, positive clip.
        cfg_fold = 1'b1;
        pulse_start();
        for (int c = 0; c < NCH; c++) send(c, 16383, 4'b0101, 0, 1'b0, e);
        expect_frame("fold_count");

        // 3: duplicate channel, frame closed by an invalid in_last beat.
        cfg_fold = 1'b0;
        pulse_start();
        send(3, 50, 4'b0001, 0, 1'b0, e);
        send(3, 50, 4'b0001, 0, 1'b0, e);
        send(25, 999, 4'b0001, 0, 1'b1, e);
        expect_frame("dup");

        // 4: abort mid-frame.
        pulse_start();
        for (int c = 0; c < 5; c++) send(c + 4, 300, 4'b1111, 0, 1'b0, e);
        pulse_start();
        send(0, 7, 4'b0001, 0, 1'b1, e);
        expect_frame("abort");

        // 5: negative saturation, then the same with maximum attenuation.
        cfg_fold = 1'b0;
        pulse_start();
        for (int c = 0; c < NCH; c++) send(c, -16384, 4'b0010, 0, 1'b0, e);
        expect_frame("neg_sat");
        cfg_fold = 1'b0;
        pulse_start();
        for (int c = 0; c < NCH; c++) send(c, -16384, 4'b0010, 7, 1'b0, e);
        expect_frame("neg_atten7");

        // Empty frame: only an invalid channel with in_last.
        pulse_start();
        send(19, 1234, 4'b1111, 0, 1'b1, e);
        expect_frame("empty");

        // 6: reset mid-frame, then a clean frame.
        pulse_start();
        send(0, 1111, 4'b1111, 0, 1'b0, e);
        send(1, 2222, 4'b1111, 0, 1'b0, e);
        do_reset();
        chk("midreset/sample", out_sample, 64'd0);
        chk("midreset/clip", {60'd0, out_clip}, 64'd0);
        chk("midreset/busy", {63'd0, busy}, 64'd0);
        chk("midreset/err_dup", {63'd0, err_dup}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midreset/no_valid", {63'd0, out_valid}, 64'd0);
            tick();
        end
        cfg_fold = 1'b0;
        pulse_start();
        send(5, -3000, 4'b1001, 2, 1'b0, e);
        send(6, 4000, 4'b0110, 3, 1'b1, e);
        expect_frame("post_reset");

        // Randomised frames.
        for (int f = 0; f < 30; f++) begin
            cfg_fold = 1'($urandom_range(0, 1));
            pulse_start();
            n = $urandom_range(1, 24);
            e = 1'b0;
            for (int i = 0; i < n && !e; i++) begin
                d = $urandom_range(0, 32767) - 16384;
                if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 16383 : -16384;
                send($urandom_range(0, 21), d, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 7), i == n - 1, e);
            end
            expect_frame("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
